// File: rtl/mat_burst_feeder.sv
`default_nettype none
// ============================================================================
// Module      : mat_burst_feeder
// Description : Buffers a valid/ready word stream in a FIFO. Once a full
//               burst is stored, it runs a req/ack handshake toward the
//               8x8 transpose stage and then emits BURST back-to-back beats.
// Revision    : 1.0 - initial release
// ============================================================================
module mat_burst_feeder #(
  parameter int DW    = 32,
  parameter int BURST = 64,
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_req,
  input  logic          m_ack,
  output logic          m_vld,
  output logic [DW-1:0] m_data,
  output logic [AW:0]   fifo_cnt,
  output logic          burst_done
);

  localparam int          BW         = $clog2(BURST);
  localparam logic [AW:0] DEPTH_C    = (AW+1)'(DEPTH);
  localparam logic [AW:0] BURST_C    = (AW+1)'(BURST);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            m_req_q, m_req_d;
  logic            m_vld_q, m_vld_d;
  logic [DW-1:0]   m_data_q, m_data_d;
  logic            done_q, done_d;

  logic [DW-1:0]   mem_q [DEPTH];
  logic            push;
  logic            pop;
  logic [DW-1:0]   rd_word;

  // Ready depends only on the stored count, so it never loops back through s_valid.
  assign s_ready = (cnt_q < DEPTH_C);
  assign push    = s_valid && s_ready;
  assign rd_word = mem_q[rd_ptr_q];

  assign m_req      = m_req_q;
  assign m_vld      = m_vld_q;
  assign m_data     = m_data_q;
  assign fifo_cnt   = cnt_q;
  assign burst_done = done_q;

  // Storage array: written on every accepted word, contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

  // Burst sequencing: the word for a beat is popped on the edge that presents it,
  // so the first pop coincides with the handshake edge.
  always_comb begin
    state_d  = state_q;
    m_req_d  = m_req_q;
    m_vld_d  = m_vld_q;
    m_data_d = m_data_q;
    beat_d   = beat_q;
    done_d   = 1'b0;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cnt_q >= BURST_C) begin
          state_d = REQ;
          m_req_d = 1'b1;
        end
      end
      REQ: begin
        if (m_ack) begin
          state_d  = SEND;
          m_req_d  = 1'b0;
          m_vld_d  = 1'b1;
          m_data_d = rd_word;
          beat_d   = '0;
          pop      = 1'b1;
        end
      end
      SEND: begin
        if (beat_q == LAST_BEAT) begin
          state_d = IDLE;
          m_vld_d = 1'b0;
          done_d  = 1'b1;
        end else begin
          m_data_d = rd_word;
          beat_d   = beat_q + 1'b1;
          pop      = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        m_req_d = 1'b0;
        m_vld_d = 1'b0;
      end
    endcase
  end

  // FIFO pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // State and output registers; reset discards any partial burst and FIFO contents.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      beat_q   <= '0;
      m_req_q  <= 1'b0;
      m_vld_q  <= 1'b0;
      m_data_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      beat_q   <= beat_d;
      m_req_q  <= m_req_d;
      m_vld_q  <= m_vld_d;
      m_data_q <= m_data_d;
      done_q   <= done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mat_burst_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mat_burst_feeder
// Description : Directed self-checking bench for mat_burst_feeder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mat_burst_feeder;

  localparam int DW    = 32;
  localparam int BURST = 64;
  localparam int DEPTH = 128;
  localparam int AW    = 7;

  logic          clk = 1'b0;
  logic          rstn;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_req;
  logic          m_ack;
  logic          m_vld;
  logic [DW-1:0] m_data;
  logic [AW:0]   fifo_cnt;
  logic          burst_done;

  int checks = 0;
  int errors = 0;

  mat_burst_feeder #(.DW(DW), .BURST(BURST), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_req      (m_req),
    .m_ack      (m_ack),
    .m_vld      (m_vld),
    .m_data     (m_data),
    .fifo_cnt   (fifo_cnt),
    .burst_done (burst_done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn    = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ack   = 1'b0;
    #2;
    step();
    check_val("rst_s_ready", 32'(s_ready), 1);
    check_val("rst_m_req", 32'(m_req), 0);
    check_val("rst_m_vld", 32'(m_vld), 0);
    check_val("rst_m_data", m_data, 0);
    check_val("rst_cnt", 32'(fifo_cnt), 0);
    check_val("rst_done", 32'(burst_done), 0);
    rstn = 1'b1;
    step();
  endtask

  task automatic push_words(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = 32'(base + i);
      step();
    end
    s_valid = 1'b0;
  endtask

  // Called right after the handshake edge; ends in the burst_done cycle.
  task automatic run_burst(input int base, input int exp_cnt);
    for (int k = 0; k < BURST; k++) begin
      check_val("beat_vld", 32'(m_vld), 1);
      check_val("beat_data", m_data, 32'(base + k));
      check_val("beat_no_req", 32'(m_req), 0);
      if (exp_cnt >= 0) check_val("send_cnt", 32'(fifo_cnt), 32'(exp_cnt));
      step();
    end
    check_val("end_vld", 32'(m_vld), 0);
    check_val("end_done", 32'(burst_done), 1);
    check_val("end_data_hold", m_data, 32'(base + BURST - 1));
  endtask

  initial begin
    rstn    = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ack   = 1'b0;

    // ---- Single burst, ack high ----
    do_reset();
    push_words(0, 64);
    check_val("t1_cnt64", 32'(fifo_cnt), 64);
    check_val("t1_no_req_yet", 32'(m_req), 0);
    m_ack = 1'b1;
    step();
    check_val("t1_req", 32'(m_req), 1);
    check_val("t1_no_vld", 32'(m_vld), 0);
    step();
    check_val("t1_cnt_after_hs", 32'(fifo_cnt), 63);
    run_burst(0, -1);
    step();
    check_val("t1_done_one", 32'(burst_done), 0);
    check_val("t1_cnt0", 32'(fifo_cnt), 0);
    check_val("t1_req_idle", 32'(m_req), 0);

    // ---- Held request ----
    m_ack = 1'b0;
    push_words(100, 64);
    step();
    for (int i = 0; i < 20; i++) begin
      check_val("t2_req_held", 32'(m_req), 1);
      check_val("t2_no_vld", 32'(m_vld), 0);
      step();
    end
    check_val("t2_req_still", 32'(m_req), 1);
    m_ack = 1'b1;
    step();
    run_burst(100, -1);
    step();

    // ---- Fill / backpressure ----
    do_reset();
    for (int i = 0; i < 128; i++) begin
      check_val("t3_ready_fill", 32'(s_ready), 1);
      s_valid = 1'b1;
      s_data  = 32'(i);
      step();
    end
    check_val("t3_cnt_full", 32'(fifo_cnt), 128);
    check_val("t3_not_ready", 32'(s_ready), 0);
    check_val("t3_req", 32'(m_req), 1);
    s_data = 32'd128;
    repeat (3) step();
    check_val("t3_cnt_hold", 32'(fifo_cnt), 128);
    check_val("t3_no_vld", 32'(m_vld), 0);
    fork
      begin : producer3
        int w;
        int guard;
        logic acc;
        w = 128;
        guard = 0;
        while (w < 130 && guard < 400) begin
          s_valid = 1'b1;
          s_data  = 32'(w);
          acc     = s_ready;
          step();
          if (acc) w++;
          guard++;
        end
        s_valid = 1'b0;
        check_val("t3_accept_all", 32'(w), 130);
      end
      begin : consumer3
        m_ack = 1'b1;
        step();
        run_burst(0, -1);
        step();
        check_val("t3_req2", 32'(m_req), 1);
        step();
        run_burst(64, -1);
      end
    join
    check_val("t3_cnt_left", 32'(fifo_cnt), 2);
    // Top up across the pointer wrap and read the held words back.
    push_words(130, 62);
    step();
    check_val("t3_req3", 32'(m_req), 1);
    step();
    run_burst(128, -1);

    // ---- Concurrent push during SEND ----
    do_reset();
    push_words(300, 64);
    step();
    check_val("t4_req", 32'(m_req), 1);
    fork
      begin : producer4
        push_words(364, 64);
      end
      begin : consumer4
        m_ack = 1'b1;
        step();
        run_burst(300, 64);
        check_val("t4_req_T65", 32'(m_req), 0);
        step();
        check_val("t4_req_T66", 32'(m_req), 1);
        check_val("t4_cnt", 32'(fifo_cnt), 64);
      end
    join
    step();
    run_burst(364, -1);
    step();
    check_val("t4_cnt0", 32'(fifo_cnt), 0);

    // ---- Short data ----
    do_reset();
    push_words(400, 63);
    for (int i = 0; i < 4; i++) begin
      check_val("t5_no_req", 32'(m_req), 0);
      step();
    end
    check_val("t5_cnt63", 32'(fifo_cnt), 63);
    push_words(463, 1);
    check_val("t5_cnt64", 32'(fifo_cnt), 64);
    step();
    check_val("t5_req", 32'(m_req), 1);
    m_ack = 1'b1;
    step();
    run_burst(400, -1);

    // ---- Reset mid-burst ----
    do_reset();
    push_words(0, 64);
    m_ack = 1'b1;
    step();
    step();
    repeat (10) step();
    check_val("t6_beat10", m_data, 10);
    check_val("t6_vld_pre", 32'(m_vld), 1);
    rstn = 1'b0;
    #2;
    check_val("t6_async_vld", 32'(m_vld), 0);
    check_val("t6_async_req", 32'(m_req), 0);
    check_val("t6_async_cnt", 32'(fifo_cnt), 0);
    check_val("t6_async_data", m_data, 0);
    step();
    rstn = 1'b1;
    step();
    push_words(200, 64);
    step();
    check_val("t6_req", 32'(m_req), 1);
    step();
    run_burst(200, -1);
    step();
    check_val("t6_cnt0", 32'(fifo_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
